// File: rtl/key_pkg.sv
// Shared definitions for the keypad entry path: special key codes, digit test
// and the press/release FSM state type.
package key_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad-to-datapath bundle: per-scan key stream in, committed operand out
// with a valid/ready handshake, plus entry status.
interface key_entry_if #(
    parameter int DIGITS = 3
);
    localparam int BIN_W = $clog2(10**DIGITS);
    localparam int CNT_W = $clog2(DIGITS+1);

    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  num_valid;
    logic                  num_ready;
    logic [4*DIGITS-1:0]   num_bcd;
    logic [BIN_W-1:0]      num_bin;
    logic [CNT_W-1:0]      digit_count;
    logic                  overflow;

    // Driven by the keypad reader / downstream consumer.
    modport master (
        output key_valid, key_code, num_ready,
        input  num_valid, num_bcd, num_bin, digit_count, overflow
    );

    // The entry block itself.
    modport slave (
        input  key_valid, key_code, num_ready,
        output num_valid, num_bcd, num_bin, digit_count, overflow
    );
endinterface

// File: rtl/key_release_det.sv
// Turns the repeating per-scan key stream into one press pulse per physical
// press; a release needs RELEASE_CYCLES quiet cycles (>= 8, two full scans).
module key_release_det
    import key_pkg::*;
#(
    parameter int RELEASE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       press,
    output logic [3:0] code
);
    localparam int RC_W = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;

    entry_state_t    state_q, state_d;
    logic [RC_W-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]      code_q, code_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rel_cnt_q <= '0;
            code_q    <= '0;
        end else begin
            // NOTE: every flop updates with <= so all state moves on the same edge.
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch can leave a latch behind.
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        code_d    = code_q;
        press     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    press     = 1'b1;
                    code_d    = key_code;
                    state_d   = HELD;
                    rel_cnt_d = '0;
                end
            end
            HELD: begin
                // Repeats of the same key or a second key are swallowed here.
                if (key_valid) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == RC_W'(RELEASE_CYCLES-1)) begin
                    state_d   = IDLE;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The action must execute on the latching edge, so forward the live code.
    assign code = press ? key_code : code_q;

endmodule

// File: rtl/key_entry.sv
// Keypad operand entry: BCD digit buffer, commit to a handshaked output register.
// Define KEY_ENTRY_BIN_EN to add a parallel binary accumulator driving num_bin.
module key_entry
    import key_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    key_entry_if.slave  bus
);
    localparam int BCD_W = 4*DIGITS;
    localparam int BIN_W = $clog2(10**DIGITS);
    localparam int CNT_W = $clog2(DIGITS+1);

    logic       press;
    logic [3:0] code;

    key_release_det #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_release_det (
        .clk       (clk),
        .rst       (rst),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .press     (press),
        .code      (code)
    );

    logic [BCD_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             out_free;

    assign out_free = !valid_q || bus.num_ready;

`ifdef KEY_ENTRY_BIN_EN
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] bin_q, bin_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffer is ordinary flops, not a memory, so it resets with the rest.
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
`ifdef KEY_ENTRY_BIN_EN
            acc_q   <= '0;
            bin_q   <= '0;
`endif
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
`ifdef KEY_ENTRY_BIN_EN
            acc_q   <= acc_d;
            bin_q   <= bin_d;
`endif
        end
    end

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        valid_d = valid_q && !bus.num_ready;
`ifdef KEY_ENTRY_BIN_EN
        acc_d   = acc_q;
        bin_d   = bin_q;
`endif
        if (press) begin
            if (is_digit(code)) begin
                if (cnt_q < CNT_W'(DIGITS)) begin
                    buf_d      = buf_q << 4;
                    buf_d[3:0] = code;
                    cnt_d      = cnt_q + 1'b1;
`ifdef KEY_ENTRY_BIN_EN
                    acc_d      = acc_q * BIN_W'(10) + BIN_W'(code);
`endif
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (code == KEY_CLEAR) begin
                buf_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
`ifdef KEY_ENTRY_BIN_EN
                acc_d = '0;
`endif
            end else if (code == KEY_ENTER && cnt_q != '0 && out_free) begin
                // Shift-left entry keeps the operand right-aligned already.
                bcd_d   = buf_q;
                valid_d = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
`ifdef KEY_ENTRY_BIN_EN
                bin_d   = acc_q;
                acc_d   = '0;
`endif
            end
        end
    end

    assign bus.num_valid   = valid_q;
    assign bus.num_bcd     = bcd_q;
    assign bus.digit_count = cnt_q;
    assign bus.overflow    = ovf_q;
`ifdef KEY_ENTRY_BIN_EN
    assign bus.num_bin     = bin_q;
`else
    assign bus.num_bin     = '0;
`endif

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry: directed scenarios plus random key traffic,
// checked against an arithmetic model of the entry/commit rules.
module tb_key_entry;
    import key_pkg::*;

    localparam int DIGITS = 3;
    localparam int RC     = 16;

    logic clk = 1'b0;
    logic rst;

    key_entry_if #(.DIGITS(DIGITS)) bus ();

    key_entry #(
        .DIGITS         (DIGITS),
        .RELEASE_CYCLES (RC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
    } out_t;

    out_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Model state: operand value, digits typed, overflow, output occupied.
    int m_val;
    int m_cnt;
    bit m_ovf;
    bit m_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [9:0] exp_bin(input int v);
`ifdef KEY_ENTRY_BIN_EN
        return 10'(v);
`else
        return 10'(v * 0);
`endif
    endfunction

    function automatic void model_reset();
        m_val  = 0;
        m_cnt  = 0;
        m_ovf  = 0;
        m_full = 0;
        exp_q.delete();
    endfunction

    function automatic void model_key(input logic [3:0] code, input bit rdy);
        bit hs     = m_full && rdy;
        bit commit = 0;
        if (code <= 4'd9) begin
            if (m_cnt < DIGITS) begin
                m_val = m_val * 10 + int'(code);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end else if (code == KEY_CLEAR) begin
            m_val = 0; m_cnt = 0; m_ovf = 0;
        end else if (code == KEY_ENTER && m_cnt > 0 && (!m_full || rdy)) begin
            exp_q.push_back('{bcd: to_bcd(m_val), bin: exp_bin(m_val)});
            commit = 1;
            m_val = 0; m_cnt = 0; m_ovf = 0;
        end
        m_full = commit ? 1'b1 : (hs ? 1'b0 : m_full);
    endfunction

    // Monitor: while an operand is presented it must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.num_valid) begin
            if (exp_q.size() == 0) begin
                check("num_valid_unexpected", 32'(bus.num_valid), 32'd0);
            end else begin
                check("num_bcd", 32'(bus.num_bcd), 32'(exp_q[0].bcd));
                check("num_bin", 32'(bus.num_bin), 32'(exp_q[0].bin));
                if (bus.num_ready) void'(exp_q.pop_front());
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic gap_cycles(input int n, input int rdy_at);
        bus.key_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.key_code  = 4'($urandom_range(0, 15));
            bus.num_ready = (i == rdy_at);
            if (i == rdy_at) m_full = 0;
            @(posedge clk); #1;
            bus.num_ready = 1'b0;
        end
    endtask

    // One physical press: accept edge, hold with scan-rate repeats, then release.
    task automatic press(input logic [3:0] code, input int hold, input int period,
                         input bit rdy, input int gap_rdy_at);
        int p = (period == 0) ? int'($urandom_range(1, 4)) : period;
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        bus.num_ready = rdy;
        model_key(code, rdy);
        @(posedge clk); #1;
        bus.num_ready = 1'b0;
        check("digit_count", 32'(bus.digit_count), 32'(m_cnt));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("num_valid", 32'(bus.num_valid), 32'(m_full));
        for (int i = 1; i < hold; i++) begin
            bus.key_valid = (i % p == 0);
            bus.key_code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : code;
            @(posedge clk); #1;
        end
        gap_cycles(RC + int'($urandom_range(0, 8)), gap_rdy_at);
    endtask

    task automatic pulse_ready();
        bus.num_ready = 1'b1;
        m_full = 0;
        @(posedge clk); #1;
        bus.num_ready = 1'b0;
        check("num_valid_after_ready", 32'(bus.num_valid), 32'(m_full));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] k;
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.num_ready = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_num_valid", 32'(bus.num_valid), 32'd0);
        check("rst_num_bcd", 32'(bus.num_bcd), 32'd0);
        check("rst_num_bin", 32'(bus.num_bin), 32'd0);
        check("rst_digit_count", 32'(bus.digit_count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        gap_cycles(3, -1);

        // 1,2,3,F at scan rate, held then released by one ready pulse.
        press(4'd1, 40, 4, 0, -1);
        press(4'd2, 40, 4, 0, -1);
        press(4'd3, 40, 4, 0, -1);
        press(KEY_ENTER, 40, 4, 0, -1);
        check("t1_bcd", 32'(bus.num_bcd), 32'h123);
`ifdef KEY_ENTRY_BIN_EN
        check("t1_bin", 32'(bus.num_bin), 32'd123);
`endif
        gap_cycles(10, -1);
        check("t1_valid_held", 32'(bus.num_valid), 32'd1);
        pulse_ready();

        // Long hold of 7 with short scan gaps: exactly one digit.
        press(4'd7, 200, 0, 0, -1);
        press(KEY_ENTER, 10, 0, 0, 5);

        // Overflow then clear.
        press(4'd9, 20, 0, 0, -1);
        press(4'd9, 20, 0, 0, -1);
        press(4'd9, 20, 0, 0, -1);
        press(4'd4, 20, 0, 0, -1);
        press(KEY_CLEAR, 20, 0, 0, -1);

        // Commit blocked by pending output, then commit on the ready edge.
        press(4'd5, 10, 0, 0, -1);
        press(KEY_ENTER, 10, 0, 0, -1);
        press(4'd6, 10, 0, 0, -1);
        press(KEY_ENTER, 10, 0, 0, -1);
        check("t4_still_5", 32'(bus.num_bcd), 32'h005);
        check("t4_count_kept", 32'(bus.digit_count), 32'd1);
        press(KEY_ENTER, 10, 0, 1, -1);
        check("t4_new_bcd", 32'(bus.num_bcd), 32'h006);
        pulse_ready();

        // Enter on empty buffer and an inert key.
        press(KEY_ENTER, 10, 0, 0, -1);
        press(4'hB, 10, 0, 0, -1);

        // Asynchronous reset while HELD with an operand pending.
        press(4'd1, 10, 0, 0, -1);
        press(KEY_ENTER, 10, 0, 0, -1);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd2;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_num_valid", 32'(bus.num_valid), 32'd0);
        check("arst_num_bcd", 32'(bus.num_bcd), 32'd0);
        check("arst_num_bin", 32'(bus.num_bin), 32'd0);
        check("arst_digit_count", 32'(bus.digit_count), 32'd0);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        bus.key_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        gap_cycles(2, -1);
        press(4'd3, 10, 0, 0, -1);
        press(KEY_ENTER, 10, 0, 0, 3);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            int sel = int'($urandom_range(0, 99));
            if (sel < 60)      k = 4'($urandom_range(0, 9));
            else if (sel < 70) k = KEY_CLEAR;
            else if (sel < 90) k = KEY_ENTER;
            else               k = 4'($urandom_range(10, 13));
            press(k, int'($urandom_range(1, 40)), 0,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, RC-1)) : -1);
        end

        if (m_full) pulse_ready();
        gap_cycles(2, -1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_num_valid", 32'(bus.num_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
